// File: rtl/td4_instr_encoder.sv
// -----------------------------------------------------------------------------
// td4_instr_encoder
//
// Purpose:
//   Inverse of the TD4 control decoder. Each request describes one instruction
//   as datapath controls (mux select, one-hot load target, jump condition,
//   immediate). The encoder turns it into the 8-bit TD4 word {opcode, imm} and
//   writes the words to consecutive program-memory addresses starting at 0.
//   Used by the bench/boot path to build program images.
//
// Optional feature (macro TD4_ENC_PAD_EN):
//   defined   : after the final word, the remaining addresses up to 2**AW-1
//               are filled with 8'h00 (ADD A,0 = NOP), one per cycle, in PAD.
//   undefined : the load ends right after the final word; PAD does not exist.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   start      in   1   begin a new load at address 0 (IDLE/DONE only)
//   in_valid   in   1   request valid
//   in_ready   out  1   request can be accepted (LOAD only)
//   in_sel     in   2   mux select: 0=A, 1=B, 2=IN port, 3=zero
//   in_load    in   4   one-hot load target {PC,OUT,B,A}
//   in_cond    in   1   PC only: 1=JNC, 0=JMP
//   in_imm     in   4   immediate, passed through
//   in_last    in   1   final request of the program
//   pm_we      out  1   program-memory write strobe
//   pm_addr    out  AW  write address
//   pm_wdata   out  8   encoded word
//   err        out  1   sticky illegal-request flag for the current load
//   done       out  1   load complete (high in DONE)
//   dbg_state  out  2   current FSM state (debug)
//
// Handshake: a request transfers on a rising edge where in_valid and in_ready
// are both high; the requester holds all in_* fields stable while in_valid is
// high and not yet accepted. in_ready never depends on in_valid.
// -----------------------------------------------------------------------------
module td4_instr_encoder #(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_sel,
   input  logic [3:0]    in_load,
   input  logic          in_cond,
   input  logic [3:0]    in_imm,
   input  logic          in_last,
   output logic          pm_we,
   output logic [AW-1:0] pm_addr,
   output logic [7:0]    pm_wdata,
   output logic          err,
   output logic          done,
   output logic [1:0]    dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
`ifdef TD4_ENC_PAD_EN
      ST_PAD  = 2'd2,
`endif
      ST_DONE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [AW-1:0]   r_ptr;
   logic            r_end;      // last word issued; leave after its pulse
   logic            r_pm_we;
   logic [AW-1:0]   r_pm_addr;
   logic [7:0]      r_pm_wdata;
   logic            r_err;

   logic            w_in_ready;
   logic            w_accept;
   logic            w_legal;
   logic [3:0]      w_opcode;
   logic            w_at_max;
   logic            w_final;
   logic            w_set_end;

   assign w_in_ready = (r_state == ST_LOAD) && !r_end;
   assign w_accept   = in_valid && w_in_ready;
   assign w_at_max   = (r_ptr == {AW{1'b1}});
   // A load ends on in_last (legal or not) or on a legal word at the top address.
   assign w_final    = w_accept && (in_last || (w_legal && w_at_max));

   // Opcode encoding. A and B take the select directly in the low bits; OUT only
   // exists for odd selects; PC needs the zero select and inverts the condition.
   always_comb begin
      w_legal  = 1'b0;
      w_opcode = 4'h0;
      case (in_load)
         4'b0001: begin
            w_legal  = 1'b1;
            w_opcode = {2'b00, in_sel};
         end
         4'b0010: begin
            w_legal  = 1'b1;
            w_opcode = {2'b01, in_sel};
         end
         4'b0100: begin
            w_legal  = in_sel[0];
            w_opcode = {2'b10, in_sel};
         end
         4'b1000: begin
            w_legal  = (in_sel == 2'b11);
            w_opcode = {3'b111, ~in_cond};
         end
         default: begin
            w_legal  = 1'b0;
            w_opcode = 4'h0;
         end
      endcase
   end

   // The FSM stays in LOAD/PAD for one extra cycle after the last word so that
   // the registered write pulse is never visible while done is high.
   always_comb begin
      w_state_nx = r_state;
      w_set_end  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nx = ST_LOAD;
         end
         ST_LOAD: begin
            if (r_end) begin
               w_state_nx = ST_DONE;
            end else if (w_final) begin
`ifdef TD4_ENC_PAD_EN
               if (w_legal && w_at_max) w_set_end  = 1'b1;
               else                     w_state_nx = ST_PAD;
`else
               w_set_end = 1'b1;
`endif
            end
         end
`ifdef TD4_ENC_PAD_EN
         ST_PAD: begin
            if (r_end)         w_state_nx = ST_DONE;
            else if (w_at_max) w_set_end  = 1'b1;
         end
`endif
         ST_DONE: begin
            if (start) w_state_nx = ST_LOAD;
         end
         default: w_state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_end      <= 1'b0;
         r_pm_we    <= 1'b0;
         r_pm_addr  <= '0;
         r_pm_wdata <= 8'h00;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_pm_we <= 1'b0;
         if (w_set_end) r_end <= 1'b1;
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  r_ptr     <= '0;
                  r_end     <= 1'b0;
                  r_err     <= 1'b0;
                  r_pm_addr <= '0;
               end
            end
            ST_LOAD: begin
               if (w_accept) begin
                  if (w_legal) begin
                     r_pm_we    <= 1'b1;
                     r_pm_addr  <= r_ptr;
                     r_pm_wdata <= {w_opcode, in_imm};
                     // Saturate at the top address: the load ends there anyway.
                     if (!w_at_max) r_ptr <= r_ptr + 1'b1;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
`ifdef TD4_ENC_PAD_EN
            ST_PAD: begin
               if (!r_end) begin
                  r_pm_we    <= 1'b1;
                  r_pm_addr  <= r_ptr;
                  r_pm_wdata <= 8'h00;
                  if (!w_at_max) r_ptr <= r_ptr + 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign in_ready  = w_in_ready;
   assign pm_we     = r_pm_we;
   assign pm_addr   = r_pm_addr;
   assign pm_wdata  = r_pm_wdata;
   assign err       = r_err;
   assign done      = (r_state == ST_DONE);
   assign dbg_state = r_state;

endmodule

// File: tb/tb_td4_instr_encoder.sv
// Bench for td4_instr_encoder: driver tasks issue requests, a reference model
// built from the TD4 encoding table predicts every program-memory write into
// exp_q, and an independent monitor pops and compares each write it observes.
module tb_td4_instr_encoder;

  localparam int AW = 4;
  localparam int TOP = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_sel = '0;
  logic [3:0]    in_load = '0;
  logic          in_cond = 1'b0;
  logic [3:0]    in_imm = '0;
  logic          in_last = 1'b0;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [7:0]    pm_wdata;
  logic          err;
  logic          done;
  logic [1:0]    dbg_state;

  td4_instr_encoder #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sel(in_sel), .in_load(in_load), .in_cond(in_cond),
    .in_imm(in_imm), .in_last(in_last),
    .pm_we(pm_we), .pm_addr(pm_addr), .pm_wdata(pm_wdata),
    .err(err), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [AW+7:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (rst_n && pm_we) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", pm_addr, pm_wdata);
      end else begin
        chk("write", {20'd0, pm_addr, pm_wdata}, {20'd0, exp_q.pop_front()});
      end
      if (done) begin
        n_cmp++; n_bad++;
        $display("FAIL we_in_done: got pm_we 1 with done 1 expected pm_we 0");
      end
    end
  end

  // reference model: the TD4 instruction table as a list of legal encodings
  typedef struct {
    logic [3:0] ld;
    logic [1:0] sl;
    bit         pc;
    logic       c;
    logic [3:0] op;
  } enc_t;
  enc_t tbl[12];

  int   m_ptr;
  bit   m_err;
  bit   m_ended;
  bit   m_full;

  function automatic void init_tbl();
    tbl[0]  = '{4'b0001, 2'd0, 1'b0, 1'b0, 4'h0};   // ADD A,Im
    tbl[1]  = '{4'b0001, 2'd1, 1'b0, 1'b0, 4'h1};   // MOV A,B
    tbl[2]  = '{4'b0001, 2'd2, 1'b0, 1'b0, 4'h2};   // IN A
    tbl[3]  = '{4'b0001, 2'd3, 1'b0, 1'b0, 4'h3};   // MOV A,Im
    tbl[4]  = '{4'b0010, 2'd0, 1'b0, 1'b0, 4'h4};   // MOV B,A
    tbl[5]  = '{4'b0010, 2'd1, 1'b0, 1'b0, 4'h5};   // ADD B,Im
    tbl[6]  = '{4'b0010, 2'd2, 1'b0, 1'b0, 4'h6};   // IN B
    tbl[7]  = '{4'b0010, 2'd3, 1'b0, 1'b0, 4'h7};   // MOV B,Im
    tbl[8]  = '{4'b0100, 2'd1, 1'b0, 1'b0, 4'h9};   // OUT B
    tbl[9]  = '{4'b0100, 2'd3, 1'b0, 1'b0, 4'hB};   // OUT Im
    tbl[10] = '{4'b1000, 2'd3, 1'b1, 1'b1, 4'hE};   // JNC
    tbl[11] = '{4'b1000, 2'd3, 1'b1, 1'b0, 4'hF};   // JMP
  endfunction

  function automatic void model_issue(input logic [3:0] ld, input logic [1:0] sl,
                                      input logic c, input logic [3:0] im, input logic lst);
    bit ok = 1'b0;
    logic [3:0] op = 4'h0;
    foreach (tbl[i])
      if (tbl[i].ld == ld && tbl[i].sl == sl && (!tbl[i].pc || tbl[i].c == c)) begin
        ok = 1'b1;
        op = tbl[i].op;
      end
    if (!ok) begin
      m_err = 1'b1;
    end else begin
      exp_q.push_back({m_ptr[AW-1:0], op, im});
      if (m_ptr == TOP) begin
        m_ended = 1'b1;
        m_full  = 1'b1;
      end else begin
        m_ptr++;
      end
    end
    if (lst) m_ended = 1'b1;
  endfunction

  function automatic void model_close();
`ifdef TD4_ENC_PAD_EN
    if (!m_full)
      for (int a = m_ptr; a <= TOP; a++) exp_q.push_back({a[AW-1:0], 8'h00});
`endif
  endfunction

  // driver tasks (called at posedge + 1)
  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    m_ptr = 0; m_err = 1'b0; m_ended = 1'b0; m_full = 1'b0;
  endtask

  task automatic send(input logic [3:0] ld, input logic [1:0] sl, input logic c,
                      input logic [3:0] im, input logic lst);
    bit ok = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    model_issue(ld, sl, c, im, lst);
    in_load = ld; in_sel = sl; in_cond = c; in_imm = im; in_last = lst;
    in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end else begin
      chk("accept_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (m_ended) model_close();
  endtask

  task automatic send_legal(input int idx, input logic lst);
    send(tbl[idx].ld, tbl[idx].sl, tbl[idx].c, 4'($urandom_range(0, 15)), lst);
  endtask

  task automatic finish_load(input string nm);
    int k = 0;
    while (!done && k < 200) begin @(negedge clk); k++; end
    chk({nm, "_done"}, {31'd0, done}, 1);
    chk({nm, "_err"}, {31'd0, err}, {31'd0, m_err});
    chk({nm, "_ready"}, {31'd0, in_ready}, 0);
    chk({nm, "_qempty"}, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic rand_load(input int n);
    logic [3:0] ld;
    for (int i = 0; i < n && !m_ended; i++) begin
      if ($urandom_range(0, 9) == 0) ld = 4'($urandom_range(0, 15));
      else ld = 4'(1 << $urandom_range(0, 3));
      send(ld, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), (i == n - 1) || ($urandom_range(0, 15) == 0));
    end
    finish_load("rand");
  endtask

  initial begin
    init_tbl();
    m_ptr = 0; m_err = 1'b0; m_ended = 1'b0; m_full = 1'b0;
    #12;
    chk("reset_outs", {26'd0, in_ready, pm_we, pm_addr == 0, pm_wdata == 0, err, done},
        {26'd0, 6'b001100});
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single MOV A,5 with last
    do_start();
    send(4'b0001, 2'd3, 1'b0, 4'd5, 1'b1);
    finish_load("t1");

    // 2: all twelve legal encodings
    do_start();
    for (int i = 0; i < 12; i++) send_legal(i, i == 11);
    finish_load("t2");

    // 3: illegal OUT sel 0 between two legal words; start then clears err
    do_start();
    send_legal(3, 1'b0);
    send(4'b0100, 2'd0, 1'b0, 4'd7, 1'b0);
    send_legal(5, 1'b1);
    finish_load("t3");
    do_start();
    chk("t3_err_clear", {31'd0, err}, 0);
    chk("t3_done_clear", {31'd0, done}, 0);

    // 4: sixteen words without last end at the top address
    for (int i = 0; i < 16; i++) send_legal($urandom_range(0, 11), 1'b0);
    finish_load("t4");

    // 5: three words, last flagged (padding when enabled)
    do_start();
    for (int i = 0; i < 3; i++) send_legal($urandom_range(0, 11), i == 2);
    finish_load("t5");

    // illegal last request still ends the load; non-one-hot target
    do_start();
    send_legal(0, 1'b0);
    send(4'b0011, 2'd3, 1'b0, 4'd1, 1'b1);
    finish_load("illegal_last");

    // 6: reset mid-load after two writes
    do_start();
    send_legal(1, 1'b0);
    send_legal(7, 1'b0);
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    chk("t6_written", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_reset_outs", {26'd0, in_ready, pm_we, pm_addr == 0, pm_wdata == 0, err, done},
        {26'd0, 6'b001100});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start();
    send_legal(9, 1'b1);
    finish_load("t6_after");

    // random programs
    for (int r = 0; r < 8; r++) begin
      do_start();
      rand_load($urandom_range(1, 20));
    end

    chk("final_qempty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
